// File: rtl/block_recon_if.sv
// Handshake and flat-bus bundle for block_recon.
// Ports (master = block producer/consumer, slave = block_recon):
//   start  request to reconstruct one block (sampled only while idle)
//   pred   prediction block, BIT_WIDTH bits per sample, element idx=r*BLOCK_SIZE+c
//   res    residual block, RES_WIDTH-bit two's complement per sample, same packing
//   recon  reconstructed block, registered, same packing as pred
//   busy   high while a block is in flight
//   done   one-cycle completion pulse
interface block_recon_if #(
   parameter int BIT_WIDTH  = 8,
   parameter int BLOCK_SIZE = 16,
   parameter int RES_WIDTH  = 12
);
   localparam int N = BLOCK_SIZE * BLOCK_SIZE;

   logic                   start;
   logic [BIT_WIDTH*N-1:0] pred;
   logic [RES_WIDTH*N-1:0] res;
   logic [BIT_WIDTH*N-1:0] recon;
   logic                   busy;
   logic                   done;

   modport master (output start, pred, res, input recon, busy, done);
   modport slave  (input start, pred, res, output recon, busy, done);
endinterface

// File: rtl/block_recon.sv
// Pixel reconstruction: recon = clip(pred + res) to [0, 2^BIT_WIDTH-1],
// one row of the block per clock.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    block_recon_if slave: start/pred/res in, recon/busy/done out
//
// state | meaning
// IDLE  | waiting for start; recon holds last block
// RUN   | writing row row_q of recon each cycle
// DONE  | all rows written; raise done for one cycle
module block_recon #(
   parameter int BIT_WIDTH  = 8,
   parameter int BLOCK_SIZE = 16,
   parameter int RES_WIDTH  = 12
) (
   input logic            clk,
   input logic            rst_n,
   block_recon_if.slave   bus
);
   localparam int N     = BLOCK_SIZE * BLOCK_SIZE;
   localparam int ROW_W = $clog2(BLOCK_SIZE);
   // one bit of headroom over the wider operand, so the sum never wraps
   localparam int SUM_W = ((BIT_WIDTH + 1 > RES_WIDTH) ? BIT_WIDTH + 1 : RES_WIDTH) + 1;
   localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(BLOCK_SIZE - 1);

   typedef enum logic [2:0] {
      IDLE = 3'b001,
      RUN  = 3'b010,
      DONE = 3'b100
   } state_t;

   state_t                 state_q, state_d;
   logic [ROW_W-1:0]       row_q, row_d;
   logic [BIT_WIDTH*N-1:0] recon_q, recon_d;
   logic                   done_q, done_d;

   function automatic logic [BIT_WIDTH-1:0] clip_pix(input logic [BIT_WIDTH-1:0] p,
                                                     input logic [RES_WIDTH-1:0] r);
      logic [SUM_W-1:0] s;
      s = {{(SUM_W-BIT_WIDTH){1'b0}}, p} + {{(SUM_W-RES_WIDTH){r[RES_WIDTH-1]}}, r};
      if (s[SUM_W-1])
         return '0;
      else if (|s[SUM_W-2:BIT_WIDTH])
         return '1;
      else
         return s[BIT_WIDTH-1:0];
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         row_q   <= '0;
         recon_q <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         recon_q <= recon_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      recon_d = recon_q;
      done_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d = RUN;
               row_d   = '0;
            end
         end
         RUN: begin
            for (int c = 0; c < BLOCK_SIZE; c++) begin
               recon_d[(int'(row_q)*BLOCK_SIZE + c)*BIT_WIDTH +: BIT_WIDTH] =
                  clip_pix(bus.pred[(int'(row_q)*BLOCK_SIZE + c)*BIT_WIDTH +: BIT_WIDTH],
                           bus.res[(int'(row_q)*BLOCK_SIZE + c)*RES_WIDTH +: RES_WIDTH]);
            end
            row_d = row_q + ROW_W'(1);
            if (row_q == LAST_ROW)
               state_d = DONE;
         end
         DONE: begin
            done_d  = 1'b1;
            state_d = IDLE;
            row_d   = '0;
         end
         default: begin
            state_d = IDLE;
            row_d   = '0;
         end
      endcase
   end

   assign bus.recon = recon_q;
   assign bus.done  = done_q;
   assign bus.busy  = (state_q != IDLE);
endmodule

// File: tb/tb_block_recon.sv
module tb_block_recon;
   localparam int BW  = 8;
   localparam int BS  = 16;
   localparam int RW  = 12;
   localparam int N   = BS * BS;
   localparam int BS2 = 4;
   localparam int RW2 = 9;
   localparam int N2  = BS2 * BS2;

   typedef struct {
      int p;
      int r;
      int exp;
   } vec_t;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   logic [BW*N-1:0]  expv;
   logic [BW*N2-1:0] expv2;

   block_recon_if #(.BIT_WIDTH(BW), .BLOCK_SIZE(BS),  .RES_WIDTH(RW))  bus1 ();
   block_recon_if #(.BIT_WIDTH(BW), .BLOCK_SIZE(BS2), .RES_WIDTH(RW2)) bus2 ();

   block_recon #(.BIT_WIDTH(BW), .BLOCK_SIZE(BS), .RES_WIDTH(RW)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus1));
   block_recon #(.BIT_WIDTH(BW), .BLOCK_SIZE(BS2), .RES_WIDTH(RW2)) dut2 (
      .clk(clk), .rst_n(rst_n), .bus(bus2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int ref_pix(int p, int r);
      int s;
      s = p + r;
      if (s < 0) return 0;
      if (s > 255) return 255;
      return s;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(string name, int got, int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic check_recon(string name);
      int bad;
      bad = -1;
      for (int i = N - 1; i >= 0; i--)
         if (bus1.recon[i*BW +: BW] !== expv[i*BW +: BW]) bad = i;
      checks++;
      if (bad >= 0) begin
         errors++;
         $display("FAIL %s: pixel %0d got %0d expected %0d", name, bad,
                  bus1.recon[bad*BW +: BW], expv[bad*BW +: BW]);
      end
   endtask

   task automatic fill_uniform(int p, int r);
      for (int i = 0; i < N; i++) begin
         bus1.pred[i*BW +: BW] = BW'(p);
         bus1.res[i*RW +: RW]  = RW'(r);
         expv[i*BW +: BW]      = BW'(ref_pix(p, r));
      end
   endtask

   // ramp prediction with a small varying residual
   task automatic fill_ramp(int rmod);
      int r;
      for (int i = 0; i < N; i++) begin
         r = (rmod == 0) ? 0 : (i % rmod) - rmod / 2;
         bus1.pred[i*BW +: BW] = BW'(i & 255);
         bus1.res[i*RW +: RW]  = RW'(r);
         expv[i*BW +: BW]      = BW'(ref_pix(i & 255, r));
      end
   endtask

   // start one block; returns edge index of done and whether busy stayed high
   task automatic run_block(output int lat, output bit busy_ok);
      bus1.start = 1'b1;
      step();
      bus1.start = 1'b0;
      lat = 0;
      busy_ok = bus1.busy;
      while (!bus1.done && lat < 40) begin
         step();
         lat++;
         if (!bus1.done && !bus1.busy) busy_ok = 1'b0;
      end
   endtask

   task automatic full_block(string name);
      int lat;
      bit busy_ok;
      run_block(lat, busy_ok);
      chk({name, "_done_edge"}, lat, BS + 1);
      chk({name, "_busy_run"}, int'(busy_ok), 1);
      chk({name, "_busy_at_done"}, int'(bus1.busy), 0);
      check_recon({name, "_recon"});
      step();
      chk({name, "_done_fall"}, int'(bus1.done), 0);
   endtask

   vec_t vecs[10];

   initial begin
      int lat, dcount, extra;
      int dedge[3];
      bit busy_ok, busy_seen;

      vecs[0] = '{250,    10, 255};
      vecs[1] = '{3,     -10,   0};
      vecs[2] = '{255, -2048,   0};
      vecs[3] = '{0,    2047, 255};
      vecs[4] = '{100,   -50,  50};
      vecs[5] = '{128,   127, 255};
      vecs[6] = '{128,  -128,   0};
      vecs[7] = '{200,    55, 255};
      vecs[8] = '{200,    54, 254};
      vecs[9] = '{77,      0,  77};

      checks = 0;
      errors = 0;
      rst_n = 1'b0;
      bus1.start = 1'b0; bus1.pred = '0; bus1.res = '0;
      bus2.start = 1'b0; bus2.pred = '0; bus2.res = '0;
      expv = '0;
      step(); step();
      chk("reset_done", int'(bus1.done), 0);
      chk("reset_busy", int'(bus1.busy), 0);
      check_recon("reset_recon");
      rst_n = 1'b1;
      step();

      // ramp, zero residual: recon must equal pred
      fill_ramp(0);
      full_block("ramp");

      // uniform vectors, including clip boundaries
      for (int v = 0; v < 10; v++) begin
         fill_uniform(vecs[v].p, vecs[v].r);
         chk($sformatf("vec%0d_model", v), int'(expv[BW-1:0]), vecs[v].exp);
         full_block($sformatf("vec%0d", v));
      end

      // start pulsed mid-RUN is ignored
      fill_ramp(7);
      bus1.start = 1'b1;
      step();
      bus1.start = 1'b0;
      repeat (4) step();
      bus1.start = 1'b1;
      step();
      bus1.start = 1'b0;
      lat = 5;
      while (!bus1.done && lat < 40) begin
         step();
         lat++;
      end
      chk("midrun_done_edge", lat, BS + 1);
      check_recon("midrun_recon");
      extra = 0;
      busy_seen = 1'b0;
      repeat (25) begin
         step();
         if (bus1.done) extra++;
         if (bus1.busy) busy_seen = 1'b1;
      end
      chk("midrun_no_second_done", extra, 0);
      chk("midrun_no_second_busy", int'(busy_seen), 0);

      // start held high: back-to-back blocks every BS+2 edges
      fill_uniform(40, 3);
      bus1.start = 1'b1;
      step();
      dcount = 0;
      for (int e = 1; e < 80 && dcount < 3; e++) begin
         step();
         if (bus1.done) begin
            dedge[dcount] = e;
            dcount++;
            if (dcount == 3) bus1.start = 1'b0;
         end
      end
      chk("b2b_count", dcount, 3);
      chk("b2b_done0", dedge[0], BS + 1);
      chk("b2b_done1", dedge[1], 2*(BS + 2) + BS + 1 - (BS + 2));
      chk("b2b_done2", dedge[2], 2*(BS + 2) + BS + 1);
      check_recon("b2b_recon");
      step();
      chk("b2b_idle_busy", int'(bus1.busy), 0);
      chk("b2b_idle_done", int'(bus1.done), 0);

      // asynchronous reset in the middle of RUN
      fill_uniform(200, 5);
      bus1.start = 1'b1;
      step();
      bus1.start = 1'b0;
      repeat (8) step();
      rst_n = 1'b0;
      #1;
      chk("abort_busy", int'(bus1.busy), 0);
      chk("abort_done", int'(bus1.done), 0);
      expv = '0;
      check_recon("abort_recon");
      step();
      rst_n = 1'b1;
      extra = 0;
      repeat (15) begin
         step();
         if (bus1.done) extra++;
      end
      chk("abort_no_done", extra, 0);
      fill_uniform(200, 5);
      full_block("after_abort");

      // small configuration, random blocks against the reference model
      for (int b = 0; b < 1000; b++) begin
         int p, r, bad;
         for (int i = 0; i < N2; i++) begin
            p = int'($urandom_range(255));
            r = int'($urandom_range(511)) - 256;
            bus2.pred[i*BW +: BW] = BW'(p);
            bus2.res[i*RW2 +: RW2] = RW2'(r);
            expv2[i*BW +: BW] = BW'(ref_pix(p, r));
         end
         bus2.start = 1'b1;
         step();
         bus2.start = 1'b0;
         lat = 0;
         while (!bus2.done && lat < 20) begin
            step();
            lat++;
         end
         chk($sformatf("small%0d_done_edge", b), lat, BS2 + 1);
         bad = -1;
         for (int i = N2 - 1; i >= 0; i--)
            if (bus2.recon[i*BW +: BW] !== expv2[i*BW +: BW]) bad = i;
         checks++;
         if (bad >= 0) begin
            errors++;
            $display("FAIL small%0d_recon: pixel %0d got %0d expected %0d", b, bad,
                     bus2.recon[bad*BW +: BW], expv2[bad*BW +: BW]);
         end
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
